// File: rtl/ble_bit_sequencer.sv
// ---------------------------------------------------------------------------
// ble_bit_sequencer
//
// Symbol-rate sequencer for the BLE transmitter. It walks the packet ROM
// address by address and holds each bit for CLK_PER_SYM clocks on the
// modulator's frequency-select input. Ramp-up and ramp-down intervals of
// RAMP_SYMS symbols frame the packet. This block is the only driver of the
// packet ROM address bus.
//
// Parameters
//   CLK_PER_SYM : clocks per symbol (>= 2)
//   PKT_LEN     : packet length in bits (1..256)
//   RAMP_SYMS   : ramp-up / ramp-down length in symbols (>= 1)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a packet (sampled only in IDLE)
//   abort      in   end the packet early (RAMP_UP / DATA only)
//   rom_addr   out  packet ROM address (registered)
//   rom_data   in   ROM bit, combinational in rom_addr
//   sym_bit    out  current symbol bit to the modulator
//   sym_valid  out  sym_bit carries packet data
//   sym_strobe out  one-cycle pulse on the first cycle of each data symbol
//   tx_en      out  transmitter / PA enable
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse on return to IDLE
// ---------------------------------------------------------------------------
module ble_bit_sequencer #(
    parameter int CLK_PER_SYM = 16,
    parameter int PKT_LEN     = 256,
    parameter int RAMP_SYMS   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] rom_addr,
    input  logic       rom_data,
    output logic       sym_bit,
    output logic       sym_valid,
    output logic       sym_strobe,
    output logic       tx_en,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(CLK_PER_SYM);
    localparam int RW = (RAMP_SYMS > 1) ? $clog2(RAMP_SYMS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_SYM - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(RAMP_SYMS - 1);
    localparam logic [8:0]    IDX_END   = 9'(PKT_LEN);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        DATA      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;     // clock within the current symbol
    logic [RW-1:0] rcnt;    // symbol within the current ramp
    logic [8:0]    idx;     // next packet bit to fetch; 9 bits so 256 is reachable

    logic sym_end;
    logic ramp_end;

    assign sym_end  = (cnt == CNT_LAST);
    assign ramp_end = sym_end && (rcnt == RCNT_LAST);

    // The address is the low byte of a register, so it stays glitch-free and
    // changes only on the strobe edge; the ROM then has a whole symbol to settle.
    assign rom_addr = idx[7:0];

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // a blocking assignment would let later statements see the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rcnt       <= '0;
            idx        <= '0;
            sym_bit    <= 1'b0;
            sym_valid  <= 1'b0;
            sym_strobe <= 1'b0;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle and are raised only
            // on the cycle they fire, so they can never stick high.
            sym_strobe <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    // abort has priority over a coincident start
                    if (start && !abort) begin
                        state <= RAMP_UP;
                        cnt   <= '0;
                        rcnt  <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        tx_en <= 1'b1;
                    end
                end

                RAMP_UP: begin
                    if (abort) begin
                        state <= RAMP_DOWN;
                        cnt   <= '0;
                        rcnt  <= '0;
                    end else if (ramp_end) begin
                        // address 0 has been on the bus for the whole ramp
                        state      <= DATA;
                        cnt        <= '0;
                        sym_bit    <= rom_data;
                        sym_valid  <= 1'b1;
                        sym_strobe <= 1'b1;
                        idx        <= 9'd1;
                    end else if (sym_end) begin
                        cnt  <= '0;
                        rcnt <= rcnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (abort) begin
                        state     <= RAMP_DOWN;
                        cnt       <= '0;
                        rcnt      <= '0;
                        sym_valid <= 1'b0;
                        sym_bit   <= 1'b0;
                    end else if (sym_end) begin
                        cnt <= '0;
                        if (idx == IDX_END) begin
                            state     <= RAMP_DOWN;
                            rcnt      <= '0;
                            sym_valid <= 1'b0;
                            sym_bit   <= 1'b0;
                        end else begin
                            sym_bit    <= rom_data;
                            sym_strobe <= 1'b1;
                            idx        <= idx + 9'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RAMP_DOWN: begin
                    // abort is deliberately ignored: the ramp always completes
                    if (ramp_end) begin
                        state <= IDLE;
                        cnt   <= '0;
                        rcnt  <= '0;
                        idx   <= '0;
                        tx_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (sym_end) begin
                        cnt  <= '0;
                        rcnt <= rcnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ble_bit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ble_bit_sequencer
//
// Two sequencer instances on one clock:
//   u_dut   : default parameters (K=16, R=4, N=256) with a modelled ROM
//   u_short : K=2, R=1, N=1, driven from a cycle-by-cycle vector table
// Cycle c is the interval after the c-th counted rising edge; inputs set in
// cycle c are captured by the edge that begins cycle c+1.
// ---------------------------------------------------------------------------
module tb_ble_bit_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic       rst_n, start, abort;
    logic [7:0] rom_addr;
    logic       rom_data, sym_bit, sym_valid, sym_strobe, tx_en, busy, done;

    // short-packet instance
    logic       rst2_n, start2, abort2;
    logic [7:0] rom_addr2;
    logic       rom_data2, sym_bit2, sym_valid2, sym_strobe2, tx_en2, busy2, done2;

    int n_cmp  = 0;
    int n_fail = 0;

    // Packet ROM model: alternating 0,1 for the first byte, then a
    // scrambled pattern so a wrong address shows up as a wrong bit.
    function automatic logic rom_fn(input logic [7:0] a);
        if (a < 8'd8) return a[0];
        return (^(a & 8'h5B)) ^ a[7];
    endfunction

    assign rom_data  = rom_fn(rom_addr);
    assign rom_data2 = (rom_addr2 == 8'd0);

    ble_bit_sequencer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sym_bit    (sym_bit),
        .sym_valid  (sym_valid),
        .sym_strobe (sym_strobe),
        .tx_en      (tx_en),
        .busy       (busy),
        .done       (done)
    );

    ble_bit_sequencer #(
        .CLK_PER_SYM (2),
        .PKT_LEN     (1),
        .RAMP_SYMS   (1)
    ) u_short (
        .clk        (clk),
        .rst_n      (rst2_n),
        .start      (start2),
        .abort      (abort2),
        .rom_addr   (rom_addr2),
        .rom_data   (rom_data2),
        .sym_bit    (sym_bit2),
        .sym_valid  (sym_valid2),
        .sym_strobe (sym_strobe2),
        .tx_en      (tx_en2),
        .busy       (busy2),
        .done       (done2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, tx_en, sym_valid, sym_strobe, sym_bit, done, rom_addr}
    function automatic logic [13:0] pack_short();
        return {busy2, tx_en2, sym_valid2, sym_strobe2, sym_bit2, done2, rom_addr2};
    endfunction

    typedef struct packed {
        logic       start;
        logic       abort;
        logic [5:0] flags;  // busy tx_en valid strobe bit done, expected next cycle
        logic [7:0] addr;   // expected rom_addr next cycle
    } vec_t;

    vec_t vecs [26];

    initial begin
        int cyc;
        int busy_cnt, n_strobe, first_strobe, last_strobe;
        int bad_gap, bad_bit, bad_addr, bad_hold, ramp_bad;
        int valid_fall, done_cyc, tx_low;
        logic       prev_valid, held_bit;
        logic [7:0] first8;

        // start abort  busy tx val stb bit done   addr  (expected in cycle c+1)
        vecs[0]  = '{1'b1, 1'b0, 6'b110000, 8'd0};  // c1  ramp-up
        vecs[1]  = '{1'b0, 1'b0, 6'b110000, 8'd0};  // c2  ramp-up
        vecs[2]  = '{1'b0, 1'b0, 6'b111110, 8'd1};  // c3  strobe, bit=rom[0]=1
        vecs[3]  = '{1'b1, 1'b0, 6'b111010, 8'd1};  // c4  start ignored while busy
        vecs[4]  = '{1'b0, 1'b0, 6'b110000, 8'd1};  // c5  ramp-down
        vecs[5]  = '{1'b0, 1'b0, 6'b110000, 8'd1};  // c6  ramp-down
        vecs[6]  = '{1'b0, 1'b0, 6'b000001, 8'd0};  // c7  done
        vecs[7]  = '{1'b0, 1'b0, 6'b000000, 8'd0};  // c8  idle
        vecs[8]  = '{1'b1, 1'b1, 6'b000000, 8'd0};  // c9  start+abort: stay idle
        vecs[9]  = '{1'b1, 1'b0, 6'b110000, 8'd0};  // c10 ramp-up
        vecs[10] = '{1'b0, 1'b1, 6'b110000, 8'd0};  // c11 abort -> ramp-down
        vecs[11] = '{1'b0, 1'b1, 6'b110000, 8'd0};  // c12 abort ignored in ramp-down
        vecs[12] = '{1'b0, 1'b0, 6'b000001, 8'd0};  // c13 done
        vecs[13] = '{1'b1, 1'b0, 6'b110000, 8'd0};  // c14 start taken in done cycle
        vecs[14] = '{1'b1, 1'b0, 6'b110000, 8'd0};  // c15
        vecs[15] = '{1'b1, 1'b0, 6'b111110, 8'd1};  // c16 strobe
        vecs[16] = '{1'b1, 1'b0, 6'b111010, 8'd1};  // c17
        vecs[17] = '{1'b1, 1'b0, 6'b110000, 8'd1};  // c18
        vecs[18] = '{1'b1, 1'b0, 6'b110000, 8'd1};  // c19
        vecs[19] = '{1'b1, 1'b0, 6'b000001, 8'd0};  // c20 done, tx_en low one cycle
        vecs[20] = '{1'b1, 1'b0, 6'b110000, 8'd0};  // c21 back-to-back restart
        vecs[21] = '{1'b0, 1'b0, 6'b110000, 8'd0};  // c22 ramp-up last cycle
        vecs[22] = '{1'b0, 1'b1, 6'b110000, 8'd0};  // c23 abort beats first strobe
        vecs[23] = '{1'b0, 1'b0, 6'b110000, 8'd0};  // c24
        vecs[24] = '{1'b0, 1'b0, 6'b000001, 8'd0};  // c25 done
        vecs[25] = '{1'b0, 1'b0, 6'b000000, 8'd0};  // c26 idle

        rst_n  = 1'b0;  start  = 1'b0;  abort  = 1'b0;
        rst2_n = 1'b0;  start2 = 1'b0;  abort2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_default",
              int'({busy, tx_en, sym_valid, sym_strobe, sym_bit, done, rom_addr}), 0);
        check("reset_outputs_short", int'(pack_short()), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        tick();

        // ---------------- short-packet vector table ----------------
        for (int i = 0; i < 26; i++) begin
            start2 = vecs[i].start;
            abort2 = vecs[i].abort;
            tick();
            check($sformatf("short_vec_c%0d", i + 1), int'(pack_short()),
                  int'({vecs[i].flags, vecs[i].addr}));
        end
        start2 = 1'b0;
        abort2 = 1'b0;

        // ---------------- full packet, default parameters ----------------
        busy_cnt = 0; n_strobe = 0; first_strobe = -1; last_strobe = -1;
        bad_gap = 0; bad_bit = 0; bad_addr = 0; bad_hold = 0; ramp_bad = 0;
        valid_fall = -1; done_cyc = -1; prev_valid = 1'b0; held_bit = 1'b0;
        first8 = '0;

        start = 1'b1;   // cycle 0
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 6000) begin
            if (busy) busy_cnt++;
            if (sym_strobe) begin
                if (n_strobe == 0) first_strobe = cyc;
                else if (cyc - last_strobe != 16) bad_gap++;
                if (sym_bit != rom_fn(n_strobe[7:0])) bad_bit++;
                if (rom_addr != 8'(n_strobe + 1)) bad_addr++;
                if (n_strobe < 8) first8[n_strobe] = sym_bit;
                held_bit    = sym_bit;
                last_strobe = cyc;
                n_strobe++;
            end else if (sym_valid && sym_bit != held_bit) begin
                bad_hold++;
            end
            if (busy && !sym_valid && (sym_bit || sym_strobe || !tx_en)) ramp_bad++;
            if (prev_valid && !sym_valid && valid_fall < 0) valid_fall = cyc;
            prev_valid = sym_valid;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        check("full_strobe_count", n_strobe, 256);
        check("full_first_strobe_cycle", first_strobe, 65);
        check("full_last_strobe_cycle", last_strobe, 4145);
        check("full_strobe_gap_errors", bad_gap, 0);
        check("full_first8_bits", int'(first8), 8'hAA);
        check("full_bit_errors", bad_bit, 0);
        check("full_addr_errors", bad_addr, 0);
        check("full_hold_errors", bad_hold, 0);
        check("full_ramp_errors", ramp_bad, 0);
        check("full_valid_fall_cycle", valid_fall, 4161);
        check("full_done_cycle", done_cyc, 4225);
        check("full_busy_cycles", busy_cnt, 4224);
        check("full_done_end_addr", int'({busy, tx_en, rom_addr}), 0);
        tick();
        check("full_done_one_cycle", int'({done, busy}), 0);

        // ---------------- abort in DATA ----------------
        start = 1'b1;   // cycle 0
        tick();
        start = 1'b0;
        for (int c = 1; c < 200; c++) tick();
        check("abort_in_data_before", int'({busy, tx_en, sym_valid}), 3'b111);
        abort = 1'b1;   // cycle 200
        tick();
        abort = 1'b0;
        check("abort_c201_outputs", int'({busy, tx_en, sym_valid, sym_bit, sym_strobe}), 5'b11000);
        cyc = 201;
        done_cyc = -1;
        tx_low = 0;
        while (cyc < 1000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!tx_en || sym_valid || sym_strobe) tx_low++;
            tick();
            cyc++;
        end
        check("abort_done_cycle", done_cyc, 265);
        check("abort_rampdown_errors", tx_low, 0);
        tick();

        // ---------------- asynchronous reset mid-DATA ----------------
        start = 1'b1;   // cycle 0
        tick();
        start = 1'b0;
        for (int c = 1; c < 1000; c++) tick();
        check("reset_pre_valid", int'({busy, sym_valid}), 2'b11);
        rst_n = 1'b0;   // cycle 1000, between edges
        #1;
        check("reset_mid_data_outputs",
              int'({busy, tx_en, sym_valid, sym_strobe, sym_bit, done, rom_addr}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        busy_cnt = 0;
        tx_low = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (busy || tx_en) busy_cnt++;
            if (done) tx_low++;
        end
        check("reset_release_idle_cycles", busy_cnt, 0);
        check("reset_release_no_done", tx_low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ble_bit_sequencer.md
# ble_bit_sequencer

Symbol-rate sequencer that walks the BLE packet ROM (`ble_packet`) address by address. It presents each packet bit to the FSK modulator for a fixed number of clocks, framed by transmitter ramp-up and ramp-down intervals. It sits between the control logic (start/abort) and the modulator's frequency-select input. It is the only driver of the packet ROM address bus.

## Interface
- `CLK_PER_SYM`, default 16: clocks per symbol. Legal range is 2 and above.
- `PKT_LEN`, default 256: packet length in bits. Legal range is 1 to 256.
- `RAMP_SYMS`, default 4: length of the ramp-up and of the ramp-down interval, in symbol periods. Legal range is 1 and above.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: begin a packet; sampled only in IDLE.
- `abort`  in  1: terminate the packet early.
- `rom_addr`  out  8: packet ROM address, registered.
- `rom_data`  in  1: ROM output. Combinational in `rom_addr`, valid in the same cycle.
- `sym_bit`  out  1: current symbol bit to the modulator.
- `sym_valid`  out  1: high while `sym_bit` carries packet data.
- `sym_strobe`  out  1: one-cycle pulse in the first cycle of each data symbol.
- `tx_en`  out  1: transmitter/PA enable.
- `busy`  out  1: high in all states except IDLE.
- `done`  out  1: one-cycle pulse when the sequencer returns to IDLE.

## Operation
- **Reset.** On `rst_n`=0: state IDLE, `rom_addr`=0, and every output (`sym_bit`, `sym_valid`, `sym_strobe`, `tx_en`, `busy`, `done`) is 0. Reset takes effect immediately, including mid-packet; no `done` pulse is produced.
- **Internal registers.**
  - Cycle counter `cnt`, running 0..CLK_PER_SYM-1.
  - Symbol counter `rcnt` for the ramp states.
  - 9-bit symbol index `idx`. `rom_addr` is `idx[7:0]`, so PKT_LEN=256 does not wrap early.
- **States.**
  - **IDLE**
    - `start`=1 and `abort`=0: go to RAMP_UP; `cnt`, `rcnt`, `idx` cleared; `rom_addr`=0.
  - **RAMP_UP**
    - `tx_en`=1, `sym_valid`=0, `sym_bit`=0. Lasts RAMP_SYMS×CLK_PER_SYM cycles.
    - On its final cycle: `sym_bit`←`rom_data` (address 0), `idx`←1, `sym_valid`←1, `sym_strobe`←1, then go to DATA.
  - **DATA**
    - Each bit is held for CLK_PER_SYM cycles.
    - At `cnt`=CLK_PER_SYM-1 with `idx`<PKT_LEN: `sym_bit`←`rom_data`, `idx`←`idx`+1, `sym_strobe`←1.
    - At `cnt`=CLK_PER_SYM-1 with `idx`=PKT_LEN: go to RAMP_DOWN, `sym_valid`←0, `sym_bit`←0.
  - **RAMP_DOWN**
    - `tx_en`=1. Lasts RAMP_SYMS×CLK_PER_SYM cycles, then go to IDLE with `done`←1 (one cycle), `tx_en`←0, `busy`←0, `rom_addr`←0.
- **Control rules.**
  - `start` is ignored when not in IDLE.
  - `abort` in RAMP_UP or DATA: next cycle enter RAMP_DOWN with `sym_valid`=0, `sym_bit`=0, `cnt`/`rcnt` cleared, full ramp-down length.
  - `abort` in RAMP_DOWN or IDLE has no effect.
  - `start` and `abort` together in IDLE: abort wins, stay in IDLE.
  - A new `start` is accepted in the cycle `done` is high.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Cycle-by-cycle sequence, with `start` sampled at edge 0 and K=CLK_PER_SYM, R=RAMP_SYMS, N=PKT_LEN:
  - From edge 1: `busy`=`tx_en`=1.
  - Edge 1+R·K: first data bit, with `sym_strobe` high.
  - Each following data bit is exactly K cycles after the previous one.
  - Edge 1+(R+N)·K: `sym_valid` falls.
  - Edge 1+(2R+N)·K: `done`=1 and `busy`=`tx_en`=0.
- `busy` is high for exactly (2R+N)·K cycles per packet.
- ROM fetch budget: `rom_addr` changes on a strobe edge and is consumed K cycles later, so the ROM gets a full symbol period to settle.
- Defaults (K=16, R=4, N=256):
  - first strobe at cycle 65;
  - last strobe at cycle 4145;
  - `sym_valid` falls at cycle 4161;
  - `done` at cycle 4225.

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-DATA at cycle 1000 -> all outputs 0 and `rom_addr`=0 immediately. After release, no `done` and IDLE.
- **Full packet with defaults.** `start` pulse at cycle 0 -> the following must hold:
  - `sym_bit` sequence equals ROM addresses 0..255; the first 8 bits are 0,1,0,1,0,1,0,1.
  - 256 strobes, 16 cycles apart.
  - `done` at cycle 4225; `busy` high for 4224 cycles.
- **Short packet.** PKT_LEN=1, K=2, R=1: `start` at 0 -> strobe at 3, `sym_valid` high for cycles 3-4, `done` at 7.
- **Abort.** Assert `abort` at cycle 200 (DATA) -> `sym_valid`=0 from 201, `tx_en` high until `done` at 201+64=265.
- **Boundary starts.**
  - Back-to-back: `start` held high continuously -> second packet's RAMP_UP begins the cycle after `done`, `tx_en` low for exactly 1 cycle.
  - `start` while busy -> ignored.
  - `start` and `abort` together in IDLE -> stays IDLE.
- **Ramp behaviour.** During ramps: `tx_en`=1, `sym_valid`=0, `sym_bit`=0, no strobes.
